cache_refill_ctrl: RTL and testbench
====================================

// Module: cache_refill_ctrl
// PURPOSE
// Cache-miss line refill controller directly upstream of the cache line data RAM. Accepts one miss,
// fetches the line from the memory bus as BEAT_W-wide beats, assembles it, then drives one-cycle
// ram_wen/ram_index/ram_wdata into the line RAM. Optionally writes back a dirty victim line first.
// PARAMETERS
// LINE_W  512  cache line width in bits (matches line RAM data width)
// BEAT_W  64   memory bus beat width; BEATS = LINE_W/BEAT_W (8), must be an integer >= 2
// IDX_W   7    line RAM entry index width (128 entries)
// ADDR_W  32   line-aligned memory address width
// PORTS
// clk            in   1       clock, all state on rising edge
// rstn           in   1       asynchronous active-low reset
// miss_valid     in   1       miss request valid
// miss_ready     out  1       controller idle, miss accepted when valid&ready
// miss_addr      in   ADDR_W  line address to refill
// miss_index     in   IDX_W   line RAM entry to fill
// victim_dirty   in   1       victim needs writeback (used only with CACHE_WB_EN)
// victim_addr    in   ADDR_W  victim line address (CACHE_WB_EN)
// victim_line    in   LINE_W  victim line data (CACHE_WB_EN)
// mem_req_valid  out  1       memory burst request valid
// mem_req_ready  in   1       memory accepts request
// mem_req_we     out  1       1=write burst, 0=read burst
// mem_req_addr   out  ADDR_W  burst address
// mem_wvalid     out  1       write beat valid
// mem_wready     in   1       write beat accepted
// mem_wdata      out  BEAT_W  write beat data
// mem_rvalid     in   1       read beat valid (no backpressure)
// mem_rdata      in   BEAT_W  read beat data
// mem_rlast      in   1       memory marks final read beat
// ram_index      out  IDX_W   line RAM entry index
// ram_wen        out  1       line RAM write enable, one-cycle pulse
// ram_wdata      out  LINE_W  assembled line
// refill_done    out  1       one-cycle pulse, same cycle as ram_wen
// rlast_err      out  1       sticky: mem_rlast disagreed with beat count
// BEHAVIOUR
// - Reset: state IDLE, beat counter 0, line buffer 0, latched addr/index 0; all outputs 0 except
//   miss_ready=1. Reset mid-burst aborts: no ram_wen, requests dropped, rlast_err cleared.
// - States IDLE, WB_REQ, WB_DATA, RF_REQ, RF_DATA, FILL. miss_ready = (state==IDLE).
// - IDLE: on miss_valid latch miss_addr, miss_index, victim_*; go WB_REQ if CACHE_WB_EN and
//   victim_dirty, else RF_REQ. miss_valid outside IDLE is not accepted.
// - WB_REQ: mem_req_valid=1, we=1, addr=victim_addr; on mem_req_ready -> WB_DATA, counter=0.
// - WB_DATA: mem_wvalid=1, mem_wdata=victim_line[cnt*BEAT_W +: BEAT_W]; counter advances on
//   mem_wvalid&mem_wready; handshake at cnt==BEATS-1 -> RF_REQ, counter=0.
// - RF_REQ: mem_req_valid=1, we=0, addr=latched miss_addr; on mem_req_ready -> RF_DATA, counter=0.
// - RF_DATA: each mem_rvalid stores mem_rdata at buffer[cnt*BEAT_W +: BEAT_W]; beat 0 = LSBs.
//   Completion by count only: beat at cnt==BEATS-1 -> FILL. rlast_err set if mem_rlast=1 at
//   cnt!=BEATS-1, or 0 at cnt==BEATS-1. mem_rvalid outside RF_DATA ignored.
// - FILL (one cycle): ram_wen=1, refill_done=1, ram_wdata=buffer; -> IDLE (new miss next cycle).
// - ram_index always drives latched index; ram_wdata always drives buffer. mem_req_valid held
//   until accepted; request fields stable while valid. Counter width clog2(BEATS), no wrap past
//   BEATS-1.
// - Latency, no writeback, ready/rvalid always high: miss accepted cycle T, ram_wen at T+2+BEATS.
// CONFIGURATION
// CACHE_WB_EN defined: dirty victim written back (WB_REQ/WB_DATA) before refill.
// CACHE_WB_EN undefined: WB states absent; victim_* ignored; mem_req_we, mem_wvalid tied 0.
// TESTING
// - Clean miss addr=0x1000 idx=5, rdata=beat k value k+1, all ready -> ram_wen at T+10, idx 5,
//   ram_wdata beats 1..8 LSB first, refill_done same cycle, miss_ready back to 1 next cycle.
// - Gaps: mem_rvalid every 3rd cycle, mem_req_ready delayed 4 cycles -> same line, req held stable.
// - rlast on beat 3 -> rlast_err=1 sticky, refill still completes after 8 beats.
// - Reset asserted during beat 4 -> outputs 0 immediately, no ram_wen; next miss refills cleanly.
// - CACHE_WB_EN, dirty victim addr=0x2000, wready toggling -> 8 write beats in order, then read
//   request addr=0x1000; not dirty -> goes straight to RF_REQ.
// - miss_valid held high through a refill -> second miss accepted only in cycle after FILL.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//   Cache-miss line refill controller sitting directly upstream of the line
//   data RAM. It accepts one miss at a time and fetches the line from memory
//   as BEATS = LINE_W/BEAT_W read beats, assembling them LSB-beat first. It
//   then writes the assembled line into the line RAM with a single-cycle
//   ram_wen pulse.
//
// Optional feature macro: CACHE_WB_EN
//   defined   : a dirty victim line is written back (one write burst) before
//               the refill read burst is issued.
//   undefined : no writeback states, victim_* and mem_wready are ignored, and
//               mem_req_we / mem_wvalid / mem_wdata are tied to zero.
//
// Ports
//   clk, rstn         clock (rising edge), asynchronous active-low reset
//   miss_valid/ready  miss handshake; ready is high only while idle
//   miss_addr/index   line address to fetch, line RAM entry to fill
//   victim_dirty/addr/line  victim line to write back first (CACHE_WB_EN)
//   mem_req_*         burst request: valid/ready, we (1=write), addr
//   mem_wvalid/wready/wdata  write beat channel (CACHE_WB_EN)
//   mem_rvalid/rdata/rlast   read beat channel, no backpressure
//   ram_index/wen/wdata      line RAM write port
//   refill_done       one-cycle pulse alongside ram_wen
//   rlast_err         sticky flag: mem_rlast disagreed with the beat count
module cache_refill_ctrl #(
    parameter int unsigned LINE_W = 512,
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned IDX_W  = 7,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic [IDX_W-1:0]  miss_index,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [LINE_W-1:0] victim_line,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_rlast,
    output logic [IDX_W-1:0]  ram_index,
    output logic              ram_wen,
    output logic [LINE_W-1:0] ram_wdata,
    output logic              refill_done,
    output logic              rlast_err
);

    localparam int unsigned BEATS = LINE_W / BEAT_W;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam int unsigned OFF_W = $clog2(LINE_W);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
`ifdef CACHE_WB_EN
        WB_REQ,
        WB_DATA,
`endif
        RF_REQ,
        RF_DATA,
        FILL
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] line_buf;
    logic [ADDR_W-1:0] line_addr;
    logic [IDX_W-1:0]  line_index;
    logic [OFF_W-1:0]  beat_off;
    logic              last_beat;

    // Bit offset of the current beat inside the line.
    assign beat_off  = OFF_W'(cnt) * OFF_W'(BEAT_W);
    assign last_beat = (cnt == LAST_BEAT);

    assign ram_index = line_index;
    assign ram_wdata = line_buf;

`ifdef CACHE_WB_EN
    logic [LINE_W-1:0] wb_line;

    assign mem_wdata = wb_line[beat_off +: BEAT_W];
`else
    logic unused_wb;

    assign mem_req_we = 1'b0;
    assign mem_wvalid = 1'b0;
    assign mem_wdata  = '0;
    assign unused_wb  = ^{victim_dirty, victim_addr, victim_line, mem_wready};
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            cnt           <= '0;
            line_buf      <= '0;
            line_addr     <= '0;
            line_index    <= '0;
            miss_ready    <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            ram_wen       <= 1'b0;
            refill_done   <= 1'b0;
            rlast_err     <= 1'b0;
`ifdef CACHE_WB_EN
            wb_line       <= '0;
            mem_req_we    <= 1'b0;
            mem_wvalid    <= 1'b0;
`endif
        end else begin
            ram_wen     <= 1'b0;
            refill_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (miss_valid) begin
                        line_addr     <= miss_addr;
                        line_index    <= miss_index;
                        miss_ready    <= 1'b0;
                        mem_req_valid <= 1'b1;
                        cnt           <= '0;
`ifdef CACHE_WB_EN
                        wb_line <= victim_line;
                        if (victim_dirty) begin
                            state        <= WB_REQ;
                            mem_req_we   <= 1'b1;
                            mem_req_addr <= victim_addr;
                        end else begin
                            state        <= RF_REQ;
                            mem_req_addr <= miss_addr;
                        end
`else
                        state        <= RF_REQ;
                        mem_req_addr <= miss_addr;
`endif
                    end
                end

`ifdef CACHE_WB_EN
                WB_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_req_we    <= 1'b0;
                        mem_wvalid    <= 1'b1;
                        cnt           <= '0;
                        state         <= WB_DATA;
                    end
                end

                // mem_wvalid is held high for the whole state, so wready alone
                // marks a completed beat.
                WB_DATA: begin
                    if (mem_wready) begin
                        if (last_beat) begin
                            mem_wvalid    <= 1'b0;
                            cnt           <= '0;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= line_addr;
                            state         <= RF_REQ;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
`endif

                RF_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= RF_DATA;
                    end
                end

                // Completion is decided by the beat count; rlast is only
                // cross-checked against it.
                RF_DATA: begin
                    if (mem_rvalid) begin
                        line_buf[beat_off +: BEAT_W] <= mem_rdata;
                        if (mem_rlast != last_beat) begin
                            rlast_err <= 1'b1;
                        end
                        if (last_beat) begin
                            cnt         <= '0;
                            ram_wen     <= 1'b1;
                            refill_done <= 1'b1;
                            state       <= FILL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                FILL: begin
                    miss_ready <= 1'b1;
                    state      <= IDLE;
                end

                default: begin
                    miss_ready    <= 1'b1;
                    mem_req_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl
//   Self-checking bench for cache_refill_ctrl. The bench plays the memory side
//   of the transaction. The expected line is the read beats packed LSB-first.
//   rlast_err is modelled as a sticky flag that is raised whenever the rlast
//   position of a burst is not the final beat, and cleared by reset.
//   Directed cases: the clean latency case, the gapped/delayed case, an early
//   rlast, held miss_valid, and reset mid-burst. Randomized misses cover the
//   rest. Writeback cases are built only with CACHE_WB_EN.
module tb_cache_refill_ctrl;

    localparam int unsigned LINE_W = 512;
    localparam int unsigned BEAT_W = 64;
    localparam int unsigned IDX_W  = 7;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BEATS  = LINE_W / BEAT_W;

    logic              clk;
    logic              rstn;
    logic              miss_valid;
    logic              miss_ready;
    logic [ADDR_W-1:0] miss_addr;
    logic [IDX_W-1:0]  miss_index;
    logic              victim_dirty;
    logic [ADDR_W-1:0] victim_addr;
    logic [LINE_W-1:0] victim_line;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [BEAT_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [BEAT_W-1:0] mem_rdata;
    logic              mem_rlast;
    logic [IDX_W-1:0]  ram_index;
    logic              ram_wen;
    logic [LINE_W-1:0] ram_wdata;
    logic              refill_done;
    logic              rlast_err;

    cache_refill_ctrl #(
        .LINE_W(LINE_W),
        .BEAT_W(BEAT_W),
        .IDX_W (IDX_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .miss_valid   (miss_valid),
        .miss_ready   (miss_ready),
        .miss_addr    (miss_addr),
        .miss_index   (miss_index),
        .victim_dirty (victim_dirty),
        .victim_addr  (victim_addr),
        .victim_line  (victim_line),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_we   (mem_req_we),
        .mem_req_addr (mem_req_addr),
        .mem_wvalid   (mem_wvalid),
        .mem_wready   (mem_wready),
        .mem_wdata    (mem_wdata),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .mem_rlast    (mem_rlast),
        .ram_index    (ram_index),
        .ram_wen      (ram_wen),
        .ram_wdata    (ram_wdata),
        .refill_done  (refill_done),
        .rlast_err    (rlast_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    int unsigned wen_seen = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ram_wen) wen_seen <= wen_seen + 1;

    int unsigned errors = 0;
    int unsigned checks = 0;
    bit          exp_rl = 1'b0;
    int unsigned exp_fills = 0;
    int unsigned t_acc = 0;

    // Current miss, as the controller should have latched it.
    logic [ADDR_W-1:0] cur_addr;
    logic [IDX_W-1:0]  cur_idx;
    logic              cur_dirty;
    logic [ADDR_W-1:0] cur_vaddr;
    logic [LINE_W-1:0] cur_vline;

    // Memory-side behaviour for the next miss.
    int unsigned cfg_delay;
    int unsigned cfg_gap;
    bit          cfg_gap_rand;
    int          cfg_rlast;
    bit          cfg_seq;
    bit          cfg_lat;
    int          cfg_abort;

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < int'(LINE_W / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic set_cfg(input int unsigned delay, input int unsigned gap,
                           input bit gap_rand, input int rl, input bit seq,
                           input bit lat, input int abort_beat);
        cfg_delay    = delay;
        cfg_gap      = gap;
        cfg_gap_rand = gap_rand;
        cfg_rlast    = rl;
        cfg_seq      = seq;
        cfg_lat      = lat;
        cfg_abort    = abort_beat;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_miss_ready"}, miss_ready, 1'b1);
        check({tag, "_ctrl_outs"},
              {mem_req_valid, mem_req_we, mem_wvalid, ram_wen, refill_done, rlast_err}, '0);
        check({tag, "_req_addr"}, mem_req_addr, '0);
        check({tag, "_wdata"}, mem_wdata, '0);
        check({tag, "_ram_index"}, ram_index, '0);
        check({tag, "_ram_wdata"}, ram_wdata, '0);
    endtask

    task automatic accept_miss(input logic [ADDR_W-1:0] a, input logic [IDX_W-1:0] idx,
                               input bit dirty, input logic [ADDR_W-1:0] va,
                               input logic [LINE_W-1:0] vl, input bit hold);
        bit ok;
        ok           = 1'b0;
        miss_valid   = 1'b1;
        miss_addr    = a;
        miss_index   = idx;
        victim_dirty = dirty;
        victim_addr  = va;
        victim_line  = vl;
        cur_addr     = a;
        cur_idx      = idx;
        cur_dirty    = dirty;
        cur_vaddr    = va;
        cur_vline    = vl;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = miss_ready;
            step();
        end
        check("miss_accept", ok, 1'b1);
        t_acc = cyc;
        if (!hold) miss_valid = 1'b0;
    endtask

    // Waits for a burst request, checks its fields, holds it for cfg_delay
    // cycles (with junk read beats that must be ignored) and accepts it.
    task automatic wait_req(input bit we, input logic [ADDR_W-1:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = mem_req_valid;
            if (!ok) step();
        end
        check(we ? "wb_req_seen" : "rd_req_seen", ok, 1'b1);
        if (!ok) return;
        check(we ? "wb_req_we" : "rd_req_we", mem_req_we, we);
        check(we ? "wb_req_addr" : "rd_req_addr", mem_req_addr, a);
        if (cfg_delay == 0) begin
            step();
        end else begin
            for (int i = 0; i < int'(cfg_delay); i++) begin
                step();
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = {$urandom, $urandom};
                @(negedge clk);
                check("req_held", {mem_req_valid, mem_req_we, mem_req_addr}, {1'b1, we, a});
            end
            step();
            mem_rvalid    = 1'b0;
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
        end
    endtask

`ifdef CACHE_WB_EN
    task automatic do_wb();
        bit ok;
        int unsigned n;
        wait_req(1'b1, cur_vaddr, ok);
        if (!ok) return;
        n = 0;
        for (int i = 0; i < 400 && n < BEATS; i++) begin
            mem_wready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("wb_wvalid", mem_wvalid, 1'b1);
            if (mem_wvalid && mem_wready) begin
                check("wb_beat", mem_wdata, cur_vline[n*BEAT_W +: BEAT_W]);
                n++;
            end
            step();
        end
        mem_wready = 1'b0;
        check("wb_beat_count", n, BEATS);
    endtask
`endif

    task automatic serve();
        logic [LINE_W-1:0] line;
        logic [BEAT_W-1:0] d;
        bit ok;
        int unsigned g;
        mem_req_ready = (cfg_delay == 0);
`ifdef CACHE_WB_EN
        if (cur_dirty) do_wb();
`endif
        wait_req(1'b0, cur_addr, ok);
        if (!ok) return;
        line = '0;
        for (int k = 0; k < int'(BEATS); k++) begin
            g = cfg_gap_rand ? $urandom_range(0, cfg_gap) : cfg_gap;
            repeat (g) step();
            d          = cfg_seq ? BEAT_W'(k + 1) : {$urandom, $urandom};
            mem_rvalid = 1'b1;
            mem_rdata  = d;
            mem_rlast  = (k == cfg_rlast);
            if (k == cfg_abort) begin
                rstn   = 1'b0;
                #1;
                exp_rl = 1'b0;
                check_reset("abort");
                mem_rvalid = 1'b0;
                mem_rlast  = 1'b0;
                step();
                step();
                rstn = 1'b1;
                step();
                step();
                check("no_fill_after_abort", wen_seen, exp_fills);
                return;
            end
            line[k*BEAT_W +: BEAT_W] = d;
            step();
            mem_rvalid = 1'b0;
            mem_rlast  = 1'b0;
        end
        if (cfg_rlast != int'(BEATS) - 1) exp_rl = 1'b1;

        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = ram_wen;
            if (!ok) step();
        end
        check("fill_seen", ok, 1'b1);
        if (!ok) return;
        exp_fills++;
        // ram_wen lands in cycle T+2+BEATS; the counter reads T+1+BEATS there.
        if (cfg_lat) check("fill_latency", cyc - t_acc, BEATS + 1);
        check("ram_index", ram_index, cur_idx);
        check("ram_wdata", ram_wdata, line);
        check("refill_done", refill_done, 1'b1);
        check("busy_at_fill", miss_ready, 1'b0);
        check("rlast_err", rlast_err, exp_rl);
        step();
        @(negedge clk);
        check("ready_after_fill", miss_ready, 1'b1);
        check("wen_one_cycle", {ram_wen, refill_done}, 2'b00);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        miss_valid    = 1'b0;
        miss_addr     = '0;
        miss_index    = '0;
        victim_dirty  = 1'b0;
        victim_addr   = '0;
        victim_line   = '0;
        mem_req_ready = 1'b0;
        mem_wready    = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        mem_rlast     = 1'b0;
        rstn          = 1'b1;
        #1;
        rstn = 1'b0;
        repeat (3) step();
        check_reset("rst");
        rstn = 1'b1;
        step();

        // Clean miss, everything ready: latency and beat ordering.
        set_cfg(0, 0, 0, BEATS - 1, 1, 1, -1);
        accept_miss(32'h1000, 7'd5, 1'b0, '0, '0, 1'b0);
        serve();

        // Same line with sparse beats and a late request acceptance.
        set_cfg(4, 2, 0, BEATS - 1, 1, 0, -1);
        accept_miss(32'h1000, 7'd5, 1'b0, '0, '0, 1'b0);
        serve();

        // rlast on beat 3: flag set, refill still runs to 8 beats.
        set_cfg(0, 0, 0, 3, 0, 0, -1);
        accept_miss(32'h3A40, 7'd17, 1'b0, '0, '0, 1'b0);
        serve();

        // miss_valid held through a refill: second miss only after FILL.
        set_cfg(1, 1, 1, BEATS - 1, 0, 0, -1);
        accept_miss(32'h4000, 7'd33, 1'b0, '0, '0, 1'b1);
        miss_addr  = 32'h5000;
        miss_index = 7'd34;
        serve();
        t_acc      = cyc;
        miss_valid = 1'b0;
        cur_addr   = 32'h5000;
        cur_idx    = 7'd34;
        cur_dirty  = 1'b0;
        serve();

        // Randomized misses; rlast_err stays sticky from above.
        for (int n = 0; n < 10; n++) begin
            set_cfg($urandom_range(0, 5), $urandom_range(0, 3), 1,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BEATS - 1)) : int'(BEATS) - 1,
                    0, 0, -1);
            accept_miss($urandom, 7'($urandom), 1'($urandom_range(0, 1)), $urandom,
                        rand_line(), 1'b0);
            serve();
        end

        // Reset during beat 4, then a clean refill.
        set_cfg(0, 0, 0, BEATS - 1, 1, 0, 4);
        accept_miss(32'h6000, 7'd9, 1'b0, '0, '0, 1'b0);
        serve();
        set_cfg(0, 0, 0, BEATS - 1, 1, 1, -1);
        accept_miss(32'h1000, 7'd5, 1'b0, '0, '0, 1'b0);
        serve();

`ifdef CACHE_WB_EN
        // Dirty victim goes out first, then the read; clean victim skips it.
        set_cfg(0, 0, 0, BEATS - 1, 0, 0, -1);
        accept_miss(32'h1000, 7'd5, 1'b1, 32'h2000, rand_line(), 1'b0);
        serve();
        set_cfg(2, 1, 1, BEATS - 1, 0, 0, -1);
        accept_miss(32'h1040, 7'd6, 1'b1, 32'h2040, rand_line(), 1'b0);
        serve();
        set_cfg(0, 0, 0, BEATS - 1, 0, 1, -1);
        accept_miss(32'h1000, 7'd5, 1'b0, 32'h2000, rand_line(), 1'b0);
        serve();
`endif

        step();
        check("fill_count", wen_seen, exp_fills);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
